// File: rtl/bundle_sequencer_if.sv
// bundle_sequencer_if: control, source-memory, adder and result-port signals of bundle_sequencer.
// master is the sequencer side; slave is the environment (memory, adder, host).
interface bundle_sequencer_if #(
   parameter int ELEMENT_WIDTH          = 64,
   parameter int HYPERVECTOR_DIMENSIONS = 100,
   parameter int NUM_PARALLEL_KERNELS   = 1,
   parameter int MAX_VECTORS            = 16
);
   localparam int W          = ELEMENT_WIDTH;
   localparam int K          = NUM_PARALLEL_KERNELS;
   localparam int NUM_CHUNKS = (HYPERVECTOR_DIMENSIONS + K - 1) / K;
   localparam int VEC_W      = $clog2(MAX_VECTORS + 1);
   localparam int CHK_W      = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
   logic                  start;
   logic [VEC_W-1:0]      num_vectors;
   logic                  busy;
   logic                  done;
   logic                  overflow_any;
   logic                  src_rd_en;
   logic [VEC_W-1:0]      src_rd_vec;
   logic [CHK_W-1:0]      src_rd_chunk;
   logic [K-1:0][W-1:0]   src_rd_data;
   logic                  add_valid;
   logic                  add_bundle_loop;
   logic [K-1:0][W-1:0]   add_elem_A;
   logic [K-1:0][W-1:0]   add_elem_B;
   logic [K-1:0][W-1:0]   add_elem_out;
   logic [K-1:0]          add_overflow;
   logic                  add_done;
   logic [CHK_W-1:0]      res_rd_addr;
   logic [K-1:0][W-1:0]   res_rd_data;
   modport master (
      input  start, num_vectors, src_rd_data, add_elem_out, add_overflow, add_done, res_rd_addr,
      output busy, done, overflow_any, src_rd_en, src_rd_vec, src_rd_chunk,
             add_valid, add_bundle_loop, add_elem_A, add_elem_B, res_rd_data
   );
   modport slave (
      output start, num_vectors, src_rd_data, add_elem_out, add_overflow, add_done, res_rd_addr,
      input  busy, done, overflow_any, src_rd_en, src_rd_vec, src_rd_chunk,
             add_valid, add_bundle_loop, add_elem_A, add_elem_B, res_rd_data
   );
endinterface

// File: rtl/bundle_sequencer.sv
// bundle_sequencer: sums num_vectors source hypervectors chunk by chunk into an accumulator via an external adder.
module bundle_sequencer #(
   parameter int ELEMENT_WIDTH          = 64,
   parameter int HYPERVECTOR_DIMENSIONS = 100,
   parameter int NUM_PARALLEL_KERNELS   = 1,
   parameter int MAX_VECTORS            = 16
) (
   input logic                 clk,
   input logic                 reset_n,
   bundle_sequencer_if.master  bus
);
   localparam int W          = ELEMENT_WIDTH;
   localparam int D          = HYPERVECTOR_DIMENSIONS;
   localparam int K          = NUM_PARALLEL_KERNELS;
   localparam int NUM_CHUNKS = (D + K - 1) / K;
   localparam int VEC_W      = $clog2(MAX_VECTORS + 1);
   localparam int CHK_W      = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
   typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, ISSUE, WAIT_ADD, WRBACK, DONE} state_t;
   state_t                state, state_nx;
   logic [VEC_W-1:0]      nv, vec;
   logic [CHK_W-1:0]      chunk;
   logic [K-1:0][W-1:0]   acc [NUM_CHUNKS];
   logic [K-1:0]          lane_ok;
   logic                  last_chunk, last_vec, accept;
   assign accept     = state == IDLE && bus.start;
   assign last_chunk = int'(chunk) == NUM_CHUNKS - 1;
   assign last_vec   = vec == nv - 1'b1;
   // lanes past the end of the hypervector in the final chunk are padding
   always_comb begin
      lane_ok = '0;
      for (int k = 0; k < K; k++) lane_ok[k] = int'(chunk) * K + k < D;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:     state_nx = !bus.start ? IDLE : bus.num_vectors == '0 ? DONE : FETCH;
         FETCH:    state_nx = WAIT_RD;
         WAIT_RD:  state_nx = ISSUE;
         ISSUE:    state_nx = WAIT_ADD;
         WAIT_ADD: state_nx = bus.add_done ? WRBACK : WAIT_ADD;
         WRBACK:   state_nx = last_chunk && last_vec ? DONE : FETCH;
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end
   assign bus.busy            = state != IDLE;
   assign bus.done            = state == DONE;
   assign bus.src_rd_en       = state == FETCH;
   assign bus.src_rd_vec      = state == FETCH ? vec : '0;
   assign bus.src_rd_chunk    = state == FETCH ? chunk : '0;
   assign bus.add_valid       = state == ISSUE;
   assign bus.add_bundle_loop = state == ISSUE && vec != '0;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nv               <= '0;
         vec              <= '0;
         chunk            <= '0;
         bus.overflow_any <= 1'b0;
         bus.add_elem_A   <= '0;
         bus.add_elem_B   <= '0;
         bus.res_rd_data  <= '0;
         for (int i = 0; i < NUM_CHUNKS; i++) acc[i] <= '0;
      end else begin
         bus.res_rd_data <= int'(bus.res_rd_addr) < NUM_CHUNKS ? acc[bus.res_rd_addr] : '0;
         if (accept) begin
            nv               <= bus.num_vectors;
            vec              <= '0;
            chunk            <= '0;
            bus.overflow_any <= 1'b0;
            for (int i = 0; i < NUM_CHUNKS; i++) acc[i] <= '0;
         end
         // operands stay frozen from here until the result is written back
         if (state == WAIT_RD)
            for (int k = 0; k < K; k++) begin
               bus.add_elem_A[k] <= lane_ok[k] ? bus.src_rd_data[k] : '0;
               bus.add_elem_B[k] <= lane_ok[k] ? acc[chunk][k] : '0;
            end
         if (state == WRBACK) begin
            for (int k = 0; k < K; k++)
               if (lane_ok[k]) acc[chunk][k] <= bus.add_elem_out[k];
            bus.overflow_any <= bus.overflow_any | (|(bus.add_overflow & lane_ok));
            chunk            <= last_chunk ? '0 : chunk + 1'b1;
            vec              <= last_chunk ? vec + 1'b1 : vec;
         end
      end
   end
endmodule

// File: tb/tb_bundle_sequencer.sv
// tb_bundle_sequencer: two sequencers (D=8 and D=6, K=4, W=16) driven by a source memory and an L=2 wrapping adder stub.
module tb_bundle_sequencer;
   localparam int W = 16, K = 4, MV = 16;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;
   logic            start_m [2];
   logic [4:0]      num_m   [2];
   logic            addr_m  [2];
   logic            stray_m [2];
   logic [K-1:0]    ovf_mask;
   logic [W-1:0]    mem [2][MV][8];
   wire logic          busy_m [2], done_m [2], valid_m [2], loop_m [2], rden_m [2], chunk_m [2], ovf_m [2];
   wire logic [4:0]    vec_m [2];
   wire logic [K*W-1:0] res_m [2];
   int total = 0, bad = 0;
   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int DG = g == 0 ? 8 : 6;
      logic d1, d2;
      logic [K-1:0][W-1:0] s_c;
      bundle_sequencer_if #(.ELEMENT_WIDTH(W), .HYPERVECTOR_DIMENSIONS(DG),
                            .NUM_PARALLEL_KERNELS(K), .MAX_VECTORS(MV)) bus();
      bundle_sequencer #(.ELEMENT_WIDTH(W), .HYPERVECTOR_DIMENSIONS(DG),
                         .NUM_PARALLEL_KERNELS(K), .MAX_VECTORS(MV)) dut (
         .clk(clk), .reset_n(reset_n), .bus(bus));
      assign bus.start       = start_m[g];
      assign bus.num_vectors = num_m[g];
      assign bus.res_rd_addr = addr_m[g];
      assign bus.add_done    = d2 | (stray_m[g] & bus.add_valid);
      assign busy_m[g]  = bus.busy;
      assign done_m[g]  = bus.done;
      assign valid_m[g] = bus.add_valid;
      assign loop_m[g]  = bus.add_bundle_loop;
      assign rden_m[g]  = bus.src_rd_en;
      assign chunk_m[g] = bus.src_rd_chunk;
      assign vec_m[g]   = bus.src_rd_vec;
      assign ovf_m[g]   = bus.overflow_any;
      assign res_m[g]   = bus.res_rd_data;
      always_comb begin
         s_c = '0;
         for (int k = 0; k < K; k++) s_c[k] = bus.add_elem_A[k] + bus.add_elem_B[k];
      end
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
         end else begin
            d1 <= bus.add_valid;
            d2 <= d1;
            for (int k = 0; k < K; k++) begin
               if (bus.add_valid) begin
                  bus.add_elem_out[k] <= s_c[k];
                  bus.add_overflow[k] <= ovf_mask[k] & (bus.add_elem_A[k][W-1] ~^ bus.add_elem_B[k][W-1])
                                         & (s_c[k][W-1] ^ bus.add_elem_A[k][W-1]);
               end
               if (bus.src_rd_en)
                  bus.src_rd_data[k] <= mem[g][bus.src_rd_vec[3:0]][{bus.src_rd_chunk, 2'(k)}];
            end
         end
   end
   task automatic model(input int s, input int n, output logic [K*W-1:0] e0, output logic [K*W-1:0] e1, output logic eo);
      logic [W-1:0] r, t, m;
      logic [8*W-1:0] all;
      all = '0;
      eo = 1'b0;
      for (int e = 0; e < (s == 0 ? 8 : 6); e++) begin
         r = '0;
         for (int v = 0; v < n; v++) begin
            m = mem[s][v][e];
            t = r + m;
            if (ovf_mask[e[1:0]] && r[W-1] == m[W-1] && t[W-1] != r[W-1]) eo = 1'b1;
            r = t;
         end
         all[e*W +: W] = r;
      end
      e0 = all[K*W-1:0];
      e1 = all[2*K*W-1:K*W];
   endtask
   task automatic run(input int s, input int n, output int done_at, output int ndone, output int nvalid,
                      output int nrd, output int nbad, output logic ovf1);
      int cyc;
      done_at = 0; ndone = 0; nvalid = 0; nrd = 0; nbad = 0; ovf1 = 1'b1;
      num_m[s] = 5'(n);
      start_m[s] = 1'b1;
      @(negedge clk);
      start_m[s] = 1'b0;
      cyc = 1;
      if (busy_m[s]) ovf1 = ovf_m[s];
      while (busy_m[s] && cyc < 3000) begin
         if (done_m[s]) begin
            ndone++;
            if (done_at == 0) done_at = cyc;
         end
         if (valid_m[s]) begin
            if (loop_m[s] !== (nvalid >= 2)) nbad++;
            nvalid++;
         end
         if (rden_m[s]) begin
            if (vec_m[s] !== 5'(nrd / 2) || chunk_m[s] !== 1'(nrd % 2)) nbad++;
            nrd++;
         end
         @(negedge clk);
         cyc++;
      end
      if (busy_m[s]) nbad++;
   endtask
   task automatic read_res(input int s, input int a, output logic [K*W-1:0] v);
      addr_m[s] = a[0];
      @(negedge clk);
      v = res_m[s];
   endtask
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         total++;
         if ({busy_m[s], done_m[s], rden_m[s], valid_m[s], loop_m[s], ovf_m[s]} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs[%0d]: got %b want 000000", s,
                     {busy_m[s], done_m[s], rden_m[s], valid_m[s], loop_m[s], ovf_m[s]});
         end
         total++;
         if (res_m[s] !== '0) begin bad++; $display("FAIL reset_res[%0d]: got %h want 0", s, res_m[s]); end
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_three_vectors();
      int da, nd, nv, nr, nb;
      logic o1;
      logic [K*W-1:0] r;
      for (int v = 0; v < 3; v++) for (int e = 0; e < 8; e++) mem[0][v][e] = 16'(v + 1);
      run(0, 3, da, nd, nv, nr, nb, o1);
      total++; if (da !== 37) begin bad++; $display("FAIL three_done_at: got %0d want 37", da); end
      total++; if (nd !== 1) begin bad++; $display("FAIL three_done_count: got %0d want 1", nd); end
      total++; if (nv !== 6 || nr !== 6) begin bad++; $display("FAIL three_issue_read: got %0d/%0d want 6/6", nv, nr); end
      total++; if (nb !== 0) begin bad++; $display("FAIL three_sequence: got %0d errors want 0", nb); end
      total++; if (ovf_m[0] !== 1'b0) begin bad++; $display("FAIL three_overflow: got %b want 0", ovf_m[0]); end
      for (int c = 0; c < 2; c++) begin
         read_res(0, c, r);
         total++; if (r !== {4{16'd6}}) begin bad++; $display("FAIL three_res[%0d]: got %h want %h", c, r, {4{16'd6}}); end
      end
   endtask
   task automatic test_random();
      int n, da, nd, nv, nr, nb;
      logic o1, eo;
      logic [K*W-1:0] r, e0, e1;
      for (int it = 0; it < 3; it++) begin
         n = $urandom_range(1, 4);
         for (int v = 0; v < n; v++) for (int e = 0; e < 8; e++) mem[0][v][e] = 16'($urandom);
         model(0, n, e0, e1, eo);
         run(0, n, da, nd, nv, nr, nb, o1);
         total++; if (da !== n * 12 + 1) begin bad++; $display("FAIL rand_done_at: got %0d want %0d", da, n * 12 + 1); end
         total++; if (nb !== 0 || nd !== 1) begin bad++; $display("FAIL rand_sequence: got %0d errors %0d dones want 0 1", nb, nd); end
         total++; if (ovf_m[0] !== eo) begin bad++; $display("FAIL rand_overflow: got %b want %b", ovf_m[0], eo); end
         read_res(0, 0, r);
         total++; if (r !== e0) begin bad++; $display("FAIL rand_res0: got %h want %h", r, e0); end
         read_res(0, 1, r);
         total++; if (r !== e1) begin bad++; $display("FAIL rand_res1: got %h want %h", r, e1); end
      end
   endtask
   task automatic test_zero();
      int da, nd, nv, nr, nb;
      logic o1;
      logic [K*W-1:0] r;
      run(0, 0, da, nd, nv, nr, nb, o1);
      total++; if (da !== 1 || nd !== 1) begin bad++; $display("FAIL zero_done: got at %0d count %0d want at 1 count 1", da, nd); end
      total++; if (nv !== 0 || nr !== 0) begin bad++; $display("FAIL zero_activity: got %0d/%0d want 0/0", nv, nr); end
      for (int c = 0; c < 2; c++) begin
         read_res(0, c, r);
         total++; if (r !== '0) begin bad++; $display("FAIL zero_res[%0d]: got %h want 0", c, r); end
      end
   endtask
   task automatic test_padding();
      int da, nd, nv, nr, nb;
      logic o1, eo;
      logic [K*W-1:0] r, e0, e1;
      for (int v = 0; v < 2; v++) begin
         for (int e = 0; e < 6; e++) mem[1][v][e] = 16'($urandom);
         mem[1][v][6] = 16'h7FFF;
         mem[1][v][7] = 16'h7FFF;
      end
      model(1, 2, e0, e1, eo);
      run(1, 2, da, nd, nv, nr, nb, o1);
      total++; if (da !== 25) begin bad++; $display("FAIL pad_done_at: got %0d want 25", da); end
      total++; if (nr !== 4 || nb !== 0) begin bad++; $display("FAIL pad_reads: got %0d reads %0d errors want 4 0", nr, nb); end
      total++; if (ovf_m[1] !== eo) begin bad++; $display("FAIL pad_overflow: got %b want %b", ovf_m[1], eo); end
      read_res(1, 0, r);
      total++; if (r !== e0) begin bad++; $display("FAIL pad_res0: got %h want %h", r, e0); end
      read_res(1, 1, r);
      total++; if (r !== e1) begin bad++; $display("FAIL pad_res1: got %h want %h", r, e1); end
      total++; if (r[4*W-1:2*W] !== '0) begin bad++; $display("FAIL pad_lanes23: got %h want 0", r[4*W-1:2*W]); end
   endtask
   task automatic test_overflow();
      int da, nd, nv, nr, nb;
      logic o1;
      logic [K*W-1:0] r;
      ovf_mask = 4'b0001;
      for (int v = 0; v < 2; v++) for (int e = 0; e < 8; e++) mem[0][v][e] = 16'h7FFF;
      run(0, 2, da, nd, nv, nr, nb, o1);
      total++; if (ovf_m[0] !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", ovf_m[0]); end
      read_res(0, 1, r);
      total++; if (r !== {4{16'hFFFE}}) begin bad++; $display("FAIL ovf_wrap_res: got %h want %h", r, {4{16'hFFFE}}); end
      ovf_mask = '1;
      for (int e = 0; e < 8; e++) mem[0][0][e] = 16'd1;
      run(0, 1, da, nd, nv, nr, nb, o1);
      total++; if (o1 !== 1'b0) begin bad++; $display("FAIL ovf_clear_on_start: got %b want 0", o1); end
      total++; if (ovf_m[0] !== 1'b0) begin bad++; $display("FAIL ovf_after_clean_run: got %b want 0", ovf_m[0]); end
   endtask
   task automatic test_abort();
      int cyc, nv, nd;
      logic [K*W-1:0] r;
      for (int v = 0; v < 2; v++) for (int e = 0; e < 8; e++) mem[0][v][e] = 16'($urandom_range(1, 1000));
      num_m[0] = 5'd2;
      start_m[0] = 1'b1;
      @(negedge clk);
      start_m[0] = 1'b0;
      num_m[0] = 5'd0;
      cyc = 1; nv = 0; nd = 0;
      while (nv < 2 && cyc < 60) begin
         if (valid_m[0]) nv++;
         if (done_m[0]) nd++;
         if (nv < 2) begin
            start_m[0] = cyc == 2;
            @(negedge clk);
            cyc++;
         end
      end
      start_m[0] = 1'b0;
      total++; if (cyc !== 9 || nd !== 0) begin bad++; $display("FAIL abort_second_issue: got cycle %0d dones %0d want 9 0", cyc, nd); end
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      total++;
      if ({busy_m[0], done_m[0], rden_m[0], valid_m[0], ovf_m[0]} !== 5'b0 || res_m[0] !== '0) begin
         bad++;
         $display("FAIL abort_reset_outputs: got %b res %h want 0", {busy_m[0], done_m[0], rden_m[0], valid_m[0], ovf_m[0]}, res_m[0]);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy_m[0] || done_m[0]) nd++;
      end
      total++; if (nd !== 0) begin bad++; $display("FAIL abort_quiet: got %0d active cycles want 0", nd); end
      for (int c = 0; c < 2; c++) begin
         read_res(0, c, r);
         total++; if (r !== '0) begin bad++; $display("FAIL abort_res[%0d]: got %h want 0", c, r); end
      end
   endtask
   task automatic test_stray_done();
      int da, nd, nv, nr, nb;
      logic o1, eo;
      logic [K*W-1:0] r, e0, e1;
      stray_m[0] = 1'b1;
      for (int v = 0; v < 2; v++) for (int e = 0; e < 8; e++) mem[0][v][e] = 16'($urandom);
      model(0, 2, e0, e1, eo);
      run(0, 2, da, nd, nv, nr, nb, o1);
      stray_m[0] = 1'b0;
      total++; if (da !== 25) begin bad++; $display("FAIL stray_done_at: got %0d want 25", da); end
      total++; if (nv !== 4 || nb !== 0 || nd !== 1) begin bad++; $display("FAIL stray_sequence: got %0d issues %0d errors %0d dones", nv, nb, nd); end
      total++; if (ovf_m[0] !== eo) begin bad++; $display("FAIL stray_overflow: got %b want %b", ovf_m[0], eo); end
      read_res(0, 0, r);
      total++; if (r !== e0) begin bad++; $display("FAIL stray_res0: got %h want %h", r, e0); end
      read_res(0, 1, r);
      total++; if (r !== e1) begin bad++; $display("FAIL stray_res1: got %h want %h", r, e1); end
   endtask
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      ovf_mask = '1;
      for (int s = 0; s < 2; s++) begin
         start_m[s] = 1'b0;
         num_m[s] = '0;
         addr_m[s] = 1'b0;
         stray_m[s] = 1'b0;
         for (int v = 0; v < MV; v++) for (int e = 0; e < 8; e++) mem[s][v][e] = '0;
      end
      #1;
      test_reset();
      test_three_vectors();
      test_random();
      test_zero();
      test_padding();
      test_overflow();
      test_abort();
      test_stray_done();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
